// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register target.
package led_driver_pkg;

    localparam int unsigned ADDR_BITS = 4;
    localparam int unsigned DATA_BITS = 8;
    localparam logic [ADDR_BITS-1:0] REG_LAST = 4'hC;

    typedef enum logic [3:0] {
        IDLE,
        DEVADDR,
        DEVACK,
        CTRL,
        CTRLACK,
        WDATA,
        WACK,
        RDATA,
        RACK
    } state_t;

    // Auto-increment wraps at the last implemented register.
    function automatic logic [ADDR_BITS-1:0] ptr_next(input logic [ADDR_BITS-1:0] p,
                                                      input logic ai);
        if (!ai) return p;
        if (p == REG_LAST) return '0;
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Register-file bus driven by the I2C target (master side) and served by the register file.
interface i2c_target_if;
    import led_driver_pkg::*;

    logic [ADDR_BITS-1:0] bus_addr;
    logic [DATA_BITS-1:0] bus_wdata;
    logic [DATA_BITS-1:0] bus_rdata;
    logic                 bus_w_en;
    logic                 bus_r_en;

    modport master (output bus_addr, bus_wdata, bus_w_en, bus_r_en, input bus_rdata);
    modport slave  (input bus_addr, bus_wdata, bus_w_en, bus_r_en, output bus_rdata);

endinterface

// File: rtl/i2c_line_cond.sv
// SCL/SDA synchronizers, optional glitch filter (I2C_GLITCH_FILTER_EN) and
// SCL edge / START / STOP detection.
module i2c_line_cond (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl;
    logic       scl_d;
    logic       sda_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;

    // A level is accepted only once three consecutive samples agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl      <= 1'b1;
            sda      <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            if (scl_hist == {2{scl_sync[1]}}) scl <= scl_sync[1];
            if (sda_hist == {2{sda_sync[1]}}) sda <= sda_sync[1];
        end
    end
`else
    assign scl = scl_sync[1];
    assign sda = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl;
            sda_d <= sda;
        end
    end

    assign scl_rise = scl & ~scl_d;
    assign scl_fall = ~scl & scl_d;
    assign start    = scl & scl_d & sda_d & ~sda;
    assign stop     = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target bridging to a register bus: [addr][ctrl: AI|ptr][data...] writes, pointer reads.
// Optional input glitch filter via I2C_GLITCH_FILTER_EN (see i2c_line_cond).
module i2c_target
    import led_driver_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h62
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         scl_in,
    input  logic         sda_in,
    output logic         sda_oe,
    i2c_target_if.master bus
);

    logic sda, scl_rise, scl_fall, start, stop;

    i2c_line_cond u_line_cond (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    state_t               state;
    logic [2:0]           bitcnt;
    logic [DATA_BITS-1:0] shreg;
    logic [ADDR_BITS-1:0] ptr;
    logic                 ai;
    logic                 rw;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic                 w_en_q;
    logic                 r_en_q;
    logic [DATA_BITS-1:0] rx_byte;
    logic                 last_bit;

    assign rx_byte  = {shreg[DATA_BITS-2:0], sda};
    assign last_bit = (bitcnt == 3'd7);

    // ACK states assert SDA on the fall after the 8th bit and leave on the next rise;
    // the following state's first fall then releases or replaces the drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bitcnt  <= '0;
            shreg   <= '0;
            ptr     <= '0;
            ai      <= 1'b0;
            rw      <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            w_en_q  <= 1'b0;
            r_en_q  <= 1'b0;
            sda_oe  <= 1'b0;
        end else begin
            w_en_q <= 1'b0;
            r_en_q <= 1'b0;
            if (r_en_q) shreg <= bus.bus_rdata;
            if (start) begin
                state  <= DEVADDR;
                bitcnt <= '0;
                sda_oe <= 1'b0;
            end else if (stop) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
            end else begin
                case (state)
                    DEVADDR: if (scl_rise) begin
                        shreg  <= rx_byte;
                        bitcnt <= bitcnt + 3'd1;
                        if (last_bit) begin
                            rw    <= sda;
                            state <= (shreg[6:0] == DEV_ADDR) ? DEVACK : IDLE;
                        end
                    end
                    DEVACK: begin
                        if (scl_fall) sda_oe <= 1'b1;
                        if (scl_rise) begin
                            bitcnt <= '0;
                            if (rw) begin
                                state  <= RDATA;
                                r_en_q <= 1'b1;
                                addr_q <= ptr;
                            end else begin
                                state <= CTRL;
                            end
                        end
                    end
                    CTRL: begin
                        if (scl_fall) sda_oe <= 1'b0;
                        if (scl_rise) begin
                            shreg  <= rx_byte;
                            bitcnt <= bitcnt + 3'd1;
                            if (last_bit) begin
                                if (rx_byte[ADDR_BITS-1:0] > REG_LAST) begin
                                    state <= IDLE;
                                end else begin
                                    ai    <= rx_byte[7];
                                    ptr   <= rx_byte[ADDR_BITS-1:0];
                                    state <= CTRLACK;
                                end
                            end
                        end
                    end
                    CTRLACK, WACK: begin
                        if (scl_fall) sda_oe <= 1'b1;
                        if (scl_rise) begin
                            bitcnt <= '0;
                            state  <= WDATA;
                        end
                    end
                    WDATA: begin
                        if (scl_fall) sda_oe <= 1'b0;
                        if (scl_rise) begin
                            shreg  <= rx_byte;
                            bitcnt <= bitcnt + 3'd1;
                            if (last_bit) begin
                                w_en_q  <= 1'b1;
                                addr_q  <= ptr;
                                wdata_q <= rx_byte;
                                ptr     <= ptr_next(ptr, ai);
                                state   <= WACK;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            sda_oe <= ~shreg[DATA_BITS-1];
                            shreg  <= {shreg[DATA_BITS-2:0], 1'b0};
                        end
                        if (scl_rise) begin
                            bitcnt <= bitcnt + 3'd1;
                            if (last_bit) state <= RACK;
                        end
                    end
                    RACK: begin
                        if (scl_fall) sda_oe <= 1'b0;
                        if (scl_rise) begin
                            if (!sda) begin
                                ptr    <= ptr_next(ptr, ai);
                                addr_q <= ptr_next(ptr, ai);
                                r_en_q <= 1'b1;
                                bitcnt <= '0;
                                state  <= RDATA;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_w_en  = w_en_q;
    assign bus.bus_r_en  = r_en_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C master plus bus-strobe scoreboard.
`timescale 1ns/1ps
module tb_i2c_target;
    import led_driver_pkg::*;

    localparam int Q = 100;

    typedef struct packed {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe;
    logic       sda_line;
    logic [7:0] rdata_val = 8'h00;
    logic       oe_seen = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;
    ev_t        exp_q[$];

    i2c_target_if bif ();

    assign sda_line      = sda_m & ~sda_oe;
    assign bif.bus_rdata = rdata_val;

    i2c_target #(.DEV_ADDR(7'h62)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .scl_in (scl),
        .sda_in (sda_line),
        .sda_oe (sda_oe),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sda_oe) oe_seen = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every bus strobe must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && (bif.bus_w_en || bif.bus_r_en)) begin
            ev_t got;
            got.wr   = bif.bus_w_en;
            got.addr = bif.bus_addr;
            got.data = bif.bus_w_en ? bif.bus_wdata : 8'h00;
            if (bif.bus_w_en && bif.bus_r_en) check("strobe_excl", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got %0h expected none", got);
            end else begin
                check("bus_event", 32'(got), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic put_bit(input logic b, output logic seen);
        sda_m = b;
        #Q scl = 1'b1;
        #Q seen = sda_line;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic put_byte(input logic [7:0] v, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) put_bit(v[i], s);
        put_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic get_byte(input logic nack, output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            put_bit(1'b1, s);
            v[i] = s;
        end
        put_bit(nack, s);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        #Q scl = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        #Q scl = 1'b1;
        #Q sda_m = 1'b1;
        #(2*Q);
    endtask

    function automatic ev_t wr_ev(input logic [3:0] a, input logic [7:0] d);
        return '{wr: 1'b1, addr: a, data: d};
    endfunction

    function automatic ev_t rd_ev(input logic [3:0] a);
        return '{wr: 1'b0, addr: a, data: 8'h00};
    endfunction

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] rb;
        logic [7:0] wr_bytes [3];
        wr_bytes[0] = 8'h11;
        wr_bytes[1] = 8'h22;
        wr_bytes[2] = 8'h33;

        // Reset values
        #50;
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_w_en", 32'(bif.bus_w_en), 32'd0);
        check("rst_r_en", 32'(bif.bus_r_en), 32'd0);
        check("rst_addr", 32'(bif.bus_addr), 32'd0);
        check("rst_wdata", 32'(bif.bus_wdata), 32'd0);
        #50 rst_n = 1'b1;
        #(2*Q);

        // Auto-increment burst write from pointer 2
        i2c_start();
        put_byte(8'hC4, ack); check("t1_addr_ack", 32'(ack), 32'd1);
        put_byte(8'h82, ack); check("t1_ctrl_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(wr_ev(4'(i + 2), wr_bytes[i]));
            put_byte(wr_bytes[i], ack);
            check("t1_data_ack", 32'(ack), 32'd1);
        end
        i2c_stop();

        // Foreign address: no ACK, no strobes, back to IDLE
        oe_seen = 1'b0;
        i2c_start();
        put_byte(8'h50, ack); check("t2_addr_nack", 32'(ack), 32'd0);
        put_byte(8'h00, ack); check("t2_data_nack", 32'(ack), 32'd0);
        check("t2_state", 32'(dut.state), 32'(IDLE));
        i2c_stop();
        check("t2_no_oe", 32'(oe_seen), 32'd0);

        // Pointer wrap from REG_LAST to 0
        i2c_start();
        put_byte(8'hC4, ack); check("t3_addr_ack", 32'(ack), 32'd1);
        put_byte(8'h8C, ack); check("t3_ctrl_ack", 32'(ack), 32'd1);
        exp_q.push_back(wr_ev(4'hC, 8'hAA));
        put_byte(8'hAA, ack); check("t3_d0_ack", 32'(ack), 32'd1);
        exp_q.push_back(wr_ev(4'h0, 8'hBB));
        put_byte(8'hBB, ack); check("t3_d1_ack", 32'(ack), 32'd1);
        i2c_stop();

        // Set pointer 5, repeated START, read one byte, master NACK
        rdata_val = 8'h5A;
        i2c_start();
        put_byte(8'hC4, ack); check("t4_addr_ack", 32'(ack), 32'd1);
        put_byte(8'h05, ack); check("t4_ctrl_ack", 32'(ack), 32'd1);
        i2c_start();
        exp_q.push_back(rd_ev(4'h5));
        put_byte(8'hC5, ack); check("t4_raddr_ack", 32'(ack), 32'd1);
        get_byte(1'b1, rb); check("t4_rdata", 32'(rb), 32'h5A);
        i2c_stop();

        // Out-of-range pointer is NACKed and nothing is written
        i2c_start();
        put_byte(8'hC4, ack); check("t5_addr_ack", 32'(ack), 32'd1);
        put_byte(8'h0F, ack); check("t5_ctrl_nack", 32'(ack), 32'd0);
        put_byte(8'h77, ack); check("t5_data_nack", 32'(ack), 32'd0);
        i2c_stop();

        // Reset during the 5th data bit
        i2c_start();
        put_byte(8'hC4, ack); check("t6_addr_ack", 32'(ack), 32'd1);
        put_byte(8'h83, ack); check("t6_ctrl_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 4; i++) put_bit(1'b1, s);
        sda_m = 1'b0;
        #Q scl = 1'b1;
        #(Q/2) rst_n = 1'b0;
        #1;
        check("t6_rst_sda_oe", 32'(sda_oe), 32'd0);
        check("t6_rst_state", 32'(dut.state), 32'(IDLE));
        sda_m = 1'b1;
        #Q rst_n = 1'b1;
        #Q;
        check("t6_ptr", 32'(dut.ptr), 32'd0);
        rdata_val = 8'h3C;
        i2c_start();
        exp_q.push_back(rd_ev(4'h0));
        put_byte(8'hC5, ack); check("t6_raddr_ack", 32'(ack), 32'd1);
        get_byte(1'b1, rb); check("t6_rdata", 32'(rb), 32'h3C);
        i2c_stop();

        #(4*Q);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h62: 7-bit I2C device address this block answers.
REQ-002 SHALL have port clk, input, 1: the only clock, a sampling clock at least 10x the SCL rate; it also clocks the register bus.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port scl_in, input, 1: raw I2C SCL.
REQ-005 SHALL have port sda_in, input, 1: raw I2C SDA.
REQ-006 SHALL have port sda_oe, output, 1: 1 pulls SDA low (open-drain); 0 releases it.
REQ-007 SHALL have port bus_addr, output, ADDR_BITS: register-file address.
REQ-008 SHALL have port bus_wdata, output, DATA_BITS: write data.
REQ-009 SHALL have port bus_rdata, input, DATA_BITS: read data, valid in the same cycle bus_r_en is high.
REQ-010 SHALL have port bus_w_en, output, 1: one-cycle write strobe.
REQ-011 SHALL have port bus_r_en, output, 1: one-cycle read strobe.

Function
REQ-012 SHALL pass SCL and SDA through 2-flop synchronizers and detect SCL rise and fall edges on the synchronized values.
REQ-013 SHALL use FSM states IDLE, DEVADDR, DEVACK, CTRL, CTRLACK, WDATA, WACK, RDATA, RACK.
REQ-014 SHALL sample SDA only on SCL rise and SHALL change sda_oe only on SCL fall.
REQ-015 START (SDA falls while SCL high) SHALL enter DEVADDR from any state, with bit counter cleared and sda_oe=0; a repeated START is handled the same way.
REQ-016 STOP (SDA rises while SCL high) SHALL enter IDLE from any state with sda_oe=0; the pointer is retained.
REQ-017 After 8 DEVADDR bits (MSB first): address match SHALL enter DEVACK with sda_oe=1 for one SCL period; mismatch SHALL enter IDLE with no ACK.
REQ-018 After DEVACK: R/W=0 SHALL go to CTRL; R/W=1 SHALL go to RDATA.
REQ-019 Control byte: bit7 SHALL load the auto-increment flag AI and bits[ADDR_BITS-1:0] SHALL load the pointer.
REQ-020 A control byte with pointer > REG_LAST SHALL be NACKed and the FSM SHALL go to IDLE; otherwise it SHALL be ACKed in CTRLACK.
REQ-021 On the SCL rise of the 8th WDATA bit, the block SHALL assert bus_w_en for exactly one clk with bus_addr=pointer and bus_wdata=received byte, then ACK in WACK.
REQ-022 After each write, the pointer SHALL increment if AI=1, wrapping REG_LAST->0; if AI=0 it SHALL hold.
REQ-023 Entering RDATA, the block SHALL assert bus_r_en for one clk with bus_addr=pointer and capture bus_rdata into the shift register in that same cycle.
REQ-024 The read byte SHALL be driven MSB first on SCL falls, with sda_oe = ~bit.
REQ-025 In RACK the block SHALL release SDA; master ACK SHALL apply the pointer update per AI and return to RDATA; master NACK SHALL go to IDLE-wait (ignore SCL until START/STOP).
REQ-026 bus_w_en and bus_r_en SHALL never be asserted in the same cycle and SHALL never be asserted outside REQ-021/REQ-023.

Reset
REQ-027 While rst_n=0: sda_oe=0, bus_w_en=0, bus_r_en=0, bus_addr=0, bus_wdata=0, pointer=0, AI=0, state=IDLE, and synchronizers set to 1.
REQ-028 Reset asserted mid-transfer SHALL abort immediately with SDA released; no strobe SHALL be issued for the partial byte.

Configuration
REQ-029 With I2C_GLITCH_FILTER_EN defined, each synchronized line SHALL change only after 3 consecutive equal samples (+2 clk latency), and pulses shorter than 3 clk SHALL be ignored.
REQ-030 Without I2C_GLITCH_FILTER_EN, only the 2-flop synchronizer SHALL be present.

Structure
REQ-031 ADDR_BITS, DATA_BITS, REG_LAST (4'hC) and the FSM state enum typedef SHALL live in led_driver_pkg.
REQ-032 The synchronizer, optional filter and edge/START/STOP detection SHALL be one sub-module, i2c_line_cond, instantiated once.

Verification
REQ-033 Bench SHALL cover: write 0xC4, ctrl 0x82, data 0x11,0x22,0x33, STOP -> w_en pulses at addr 2,3,4 with those data; ACK on every byte.
REQ-034 Bench SHALL cover: address 0x50 -> no ACK at any bit, no strobes, FSM IDLE.
REQ-035 Bench SHALL cover: ctrl 0x8C, data 0xAA,0xBB -> writes at addr 0xC then 0x0 (wrap).
REQ-036 Bench SHALL cover: ctrl 0x05, repeated START, read 0xC5 with bus_rdata=0x5A, master NACK -> SDA carries 0x5A, one r_en pulse at addr 5.
REQ-037 Bench SHALL cover: ctrl 0x0F -> NACK, no write.
REQ-038 Bench SHALL cover: rst_n low during the 5th bit of a data byte -> sda_oe=0 immediately, no w_en, pointer=0 after release.
